rotation_min_finder: RTL
========================

Name: rotation_min_finder

Overview:
- Sequential front-end wrapped around the 4-bit barrel shifter datapath.
- Accepts one 4-bit word over a valid/ready handshake and drives the shifter through shift amounts 0..3, one per cycle.
- Returns the numerically smallest rotation (the canonical necklace form) and the shift amount that produced it.
- Upstream codec logic uses it to normalise rotation-invariant patterns before lookup.

Parameters:
- DATA_W, 4, data width. Only 4 is supported, because the shifter is fixed at 4 bits.
- SHIFT_W, 2, shift-amount width; equals log2(DATA_W).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word; high only in IDLE
- in_d  input  4  word to normalise
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_min  output  4  smallest rotation of the accepted word
- out_s  output  2  rotate-left amount giving out_min
- out_d  output  4  echo of the accepted word
- busy  output  1  high in SCAN or HOLD

Behaviour:
- One clock; reset is synchronous and active-high. On rst at a clk edge:
  - state=IDLE, scan counter=0, out_valid=0, busy=0.
  - out_min, out_s, out_d and internal best registers all clear to 0.
  - in_ready=1 from the first cycle after reset.
- Rotation is rotate-left: y[i]=d[(i-s) mod 4]. Example: d=1101 gives s1=1011, s2=0111, s3=1110.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: latch in_d into d_reg, set cnt=0, go to SCAN.
- SCAN:
  - Shifter inputs are d_reg and s=cnt, combinational; y is sampled each edge.
  - cnt=0: best<=y, best_s<=0.
  - cnt=1..3: if y<best (unsigned, strict), then best<=y and best_s<=cnt. Ties keep the lower shift.
  - cnt=3: at the edge, load out_min with the final best (including the cnt=3 comparison), out_s likewise, out_d<=d_reg. Set out_valid=1 and go to HOLD.
  - Otherwise cnt<=cnt+1. SCAN lasts exactly 4 cycles; cnt never wraps inside SCAN.
- HOLD:
  - out_valid=1; out_min, out_s and out_d stay stable.
  - On out_valid&out_ready at an edge: out_valid<=0, go to IDLE. Output registers keep their last values.
  - If out_ready stays low, HOLD lasts indefinitely.
- in_ready=0 in SCAN and HOLD. in_d and in_valid are ignored outside IDLE. No accept in the same cycle as an output handshake.
- Latency: out_valid rises 4 edges after the accept edge.
- Throughput: with out_ready held high, at most one word per 6 cycles.
- Degenerate words (0000, 1111, 0101, 1010): repeated equal rotations resolve to the lowest s.
- rst mid-SCAN or mid-HOLD aborts immediately. No output is produced for the aborted word and the next cycle behaves as post-reset.
- rst has priority over every handshake in the same cycle.

Decomposition:
- Shared package rot_pkg:
  - state enum {IDLE, SCAN, HOLD}, 2-bit encoding.
  - DATA_W=4, SHIFT_W=2, LAST_S=2'd3.
- Sub-module: instantiate the existing barrel_shifter_4bit (ports y, d, s) unmodified as the rotate datapath.
- The FSM, counter, comparator and output registers live in rotation_min_finder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, busy=0, in_ready=1, out_min=0000, out_s=00.
- Basic scan: accept in_d=1101 with out_ready=1 -> out_valid 4 edges later with out_min=0111, out_s=10, out_d=1101; in_ready low for exactly 5 cycles.
- Tie handling: in_d=1010 -> out_min=0101, out_s=01 (not 11). in_d=0011 -> out_min=0011, out_s=00. in_d=1000 -> out_min=0001, out_s=01.
- Backpressure: in_d=1110, out_ready=0 for 10 cycles:
  - out_valid stays 1 with out_min=0111, out_s=11 stable.
  - in_valid held high with a new word is not accepted.
  - Raise out_ready -> IDLE next cycle, then the new word is accepted.
- Reset mid-scan: accept 1101, assert rst at the second SCAN edge -> no out_valid pulse. A following word 1000 returns out_min=0001, out_s=01 with normal 4-edge latency.
- Back-to-back stream: 6 random words with in_valid and out_ready held high -> one result per 6 cycles, each matching the bench's rotate-left min/lowest-s model.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and constants for the rotation-minimum finder.
package rot_pkg;

   localparam int unsigned DATA_W  = 4;
   localparam int unsigned SHIFT_W = 2;
   localparam logic [SHIFT_W-1:0] LAST_S = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/barrel_shifter_4bit.sv
// 4-bit rotate-left barrel shifter: y[i] = d[(i - s) mod 4].
module barrel_shifter_4bit (
   output logic [3:0] y,
   input  logic [3:0] d,
   input  logic [1:0] s
);

   always_comb begin
      y = d;
      case (s)
         2'd0: y = d;
         2'd1: y = {d[2:0], d[3]};
         2'd2: y = {d[1:0], d[3:2]};
         2'd3: y = {d[0], d[3:1]};
         default: y = d;
      endcase
   end

endmodule

// File: rtl/rotation_min_finder.sv
// Sequential front-end that sweeps a 4-bit word through all rotations and
// returns the smallest one (canonical necklace form) with its shift amount.
module rotation_min_finder
   import rot_pkg::*;
#(
   parameter int unsigned DATA_W  = 4,  // only 4 works: the shifter is fixed-width
   parameter int unsigned SHIFT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_min,
   output logic [SHIFT_W-1:0] out_s,
   output logic [DATA_W-1:0]  out_d,
   output logic               busy
);

   state_t             state;
   logic [SHIFT_W-1:0] cnt;
   logic [DATA_W-1:0]  d_reg;
   logic [DATA_W-1:0]  best;
   logic [SHIFT_W-1:0] best_s;
   logic [DATA_W-1:0]  y;
   logic               take;
   logic [DATA_W-1:0]  best_nxt;
   logic [SHIFT_W-1:0] best_s_nxt;

   barrel_shifter_4bit u_shift (
      .y (y),
      .d (d_reg),
      .s (cnt)
   );

   // Strict less-than keeps the lowest shift on ties; cnt==0 seeds the search.
   always_comb begin
      take       = (cnt == '0) || (y < best);
      best_nxt   = take ? y : best;
      best_s_nxt = take ? cnt : best_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         d_reg     <= '0;
         best      <= '0;
         best_s    <= '0;
         out_min   <= '0;
         out_s     <= '0;
         out_d     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  d_reg    <= in_d;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               best   <= best_nxt;
               best_s <= best_s_nxt;
               if (cnt == LAST_S) begin
                  out_min   <= best_nxt;
                  out_s     <= best_s_nxt;
                  out_d     <= d_reg;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
